phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Phase sequencer: timed phases with pause and manual stepping.
// Optional cycle_done output when PHASE_SEQ_CYCLE_IRQ_EN is defined.
module phase_sequencer #(
   parameter int NUM_PHASES = 3,
   parameter int CNT_W      = 8,
   parameter int IDX_W      = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        progressive,
   input  logic                        regressive,
   input  logic [NUM_PHASES*CNT_W-1:0] dur,
   output logic [IDX_W-1:0]            phase_idx,
   output logic [NUM_PHASES-1:0]       phase_onehot,
   output logic [CNT_W-1:0]            cnt,
`ifdef PHASE_SEQ_CYCLE_IRQ_EN
   output logic                        cycle_done,
`endif
   output logic                        phase_done,
   output logic                        busy,
   output logic                        paused
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             cyc_q, cyc_d;
   logic [CNT_W-1:0] cur_dur;
   logic [IDX_W-1:0] idx_inc, idx_dec;
   logic             step_fwd, step_bwd;

   always_comb begin
      cur_dur = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (idx_q == IDX_W'(k)) cur_dur = dur[k*CNT_W +: CNT_W];
      end
   end

   assign idx_inc  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
   assign idx_dec  = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
   // Simultaneous forward and backward requests cancel out.
   assign step_fwd = progressive & ~regressive;
   assign step_bwd = regressive & ~progressive;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      cyc_d   = 1'b0;
      if (stop) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               idx_d = '0;
               cnt_d = '0;
               if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (start) begin
                  state_d = ST_PAUSE;
               end else if (step_fwd) begin
                  idx_d = idx_inc;
                  cnt_d = '0;
               end else if (step_bwd) begin
                  idx_d = idx_dec;
                  cnt_d = '0;
               end else if (cnt_q >= cur_dur) begin
                  idx_d  = idx_inc;
                  cnt_d  = '0;
                  done_d = 1'b1;
                  cyc_d  = (idx_q == LAST_IDX);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_PAUSE: begin
               if (start) begin
                  state_d = ST_RUN;
               end else if (step_fwd) begin
                  idx_d = idx_inc;
                  cnt_d = '0;
               end else if (step_bwd) begin
                  idx_d = idx_dec;
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         cyc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         cyc_q   <= cyc_d;
      end
   end

   always_comb begin
      phase_onehot = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         phase_onehot[k] = (state_q != ST_IDLE) && (idx_q == IDX_W'(k));
      end
   end

   assign phase_idx  = idx_q;
   assign cnt        = cnt_q;
   assign phase_done = done_q;
   assign busy       = (state_q == ST_RUN);
   assign paused     = (state_q == ST_PAUSE);

`ifdef PHASE_SEQ_CYCLE_IRQ_EN
   assign cycle_done = cyc_q;
`else
   logic unused_cyc;
   assign unused_cyc = cyc_q;
`endif

endmodule
